// File: rtl/instr_loader.sv
// Boot-time program loader: assembles 16-bit instructions from a byte stream,
// writes them to instruction memory, and releases the core only after a clean checksum.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_hi;
    logic [7:0]        r_chk;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_cnt;

    logic              w_xfer;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [7:0]        w_chk_nxt;

    assign w_xfer    = in_valid & in_ready;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_chk_nxt = r_chk ^ in_byte;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_chk    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_run  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; only the LO transfer re-arms it.
            im_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state  <= S_CNT;
                        r_idx    <= '0;
                        r_chk    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_run  <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                S_CNT: begin
                    if (w_xfer) begin
                        if (in_byte == 8'h00) begin
                            r_state  <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            r_state <= S_HI;
                            r_cnt   <= ADDR_W'(in_byte);
                            r_chk   <= in_byte;
                        end
                    end
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_state <= S_LO;
                        r_hi    <= in_byte;
                        r_chk   <= w_chk_nxt;
                    end
                end
                S_LO: begin
                    if (w_xfer) begin
                        im_we    <= 1'b1;
                        im_addr  <= r_idx;
                        im_wdata <= {r_hi, in_byte};
                        r_chk    <= w_chk_nxt;
                        r_idx    <= w_idx_nxt;
                        // N never exceeds 255, so idx+1 reaches N before it can wrap.
                        r_state  <= (w_idx_nxt == r_cnt) ? S_CHK : S_HI;
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_byte == r_chk) begin
                            r_state <= S_DONE;
                            cpu_run <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_run  <= 1'b0;
                end
            endcase
        end
    end

endmodule
